// File: rtl/unidad_mult_div.sv
// unidad_mult_div: iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers (shift-add / restoring divide).
// Define MULT_DIV_SIGNED_EN for signed MULT/DIV; otherwise every operation is unsigned.
module unidad_mult_div #(
  parameter int ANCHO = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inicio,
  input  logic [1:0]       operacion,
  input  logic [ANCHO-1:0] operando_a,
  input  logic [ANCHO-1:0] operando_b,
  input  logic             escribe_hi,
  input  logic             escribe_lo,
  input  logic [ANCHO-1:0] dato_mt,
  output logic             ocupado,
  output logic             listo,
  output logic             div_cero,
  output logic [ANCHO-1:0] hi,
  output logic [ANCHO-1:0] lo
);
  localparam int CW = $clog2(ANCHO);
  typedef enum logic [1:0] {IDLE, CALC, AJUSTE, FIN} estado_t;
  estado_t estado, siguiente;
  logic [CW-1:0] cnt;
  logic [2*ANCHO-1:0] p, res;
  logic [ANCHO-1:0] b, mag_a, mag_b, hi_res;
  logic [ANCHO:0] suma, dif;
  logic is_div, dz;
`ifdef MULT_DIV_SIGNED_EN
  logic sgn, neg_res, neg_rem;
  assign sgn = ~operacion[0];
  assign mag_a = (sgn && operando_a[ANCHO-1]) ? -operando_a : operando_a;
  assign mag_b = (sgn && operando_b[ANCHO-1]) ? -operando_b : operando_b;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
    end else if (estado == IDLE && inicio) begin
      neg_res <= sgn && (operando_a[ANCHO-1] ^ operando_b[ANCHO-1]);
      neg_rem <= sgn && operando_a[ANCHO-1];
    end
  // low half of the negated register is the negated quotient, so LO shares one negator
  assign res = neg_res ? -p : p;
  assign hi_res = !is_div ? res[2*ANCHO-1:ANCHO] :
                  neg_rem ? -p[2*ANCHO-1:ANCHO] : p[2*ANCHO-1:ANCHO];
`else
  logic unused_op0;
  assign unused_op0 = operacion[0];
  assign mag_a = operando_a;
  assign mag_b = operando_b;
  assign res = p;
  assign hi_res = p[2*ANCHO-1:ANCHO];
`endif
  assign ocupado = (estado == CALC) || (estado == AJUSTE);
  assign listo = (estado == FIN);
  assign div_cero = (estado == FIN) && dz;
  // p holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign suma = {1'b0, p[2*ANCHO-1:ANCHO]} + (p[0] ? {1'b0, b} : '0);
  assign dif = p[2*ANCHO-1:ANCHO-1] - {1'b0, b};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) estado <= IDLE;
    else estado <= siguiente;
  always_comb begin
    siguiente = estado;
    unique case (estado)
      IDLE:    if (inicio) siguiente = (operacion[1] && operando_b == '0) ? AJUSTE : CALC;
      CALC:    if (cnt == CW'(ANCHO-1)) siguiente = AJUSTE;
      AJUSTE:  siguiente = FIN;
      default: siguiente = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      p <= '0;
      b <= '0;
      is_div <= 1'b0;
      dz <= 1'b0;
      cnt <= '0;
      hi <= '0;
      lo <= '0;
    end else begin
      unique case (estado)
        IDLE:
          if (inicio) begin
            p <= {{ANCHO{1'b0}}, mag_a};
            b <= mag_b;
            is_div <= operacion[1];
            dz <= operacion[1] && operando_b == '0;
            cnt <= '0;
          end else begin
            if (escribe_hi) hi <= dato_mt;
            if (escribe_lo) lo <= dato_mt;
          end
        CALC: begin
          cnt <= cnt + 1'b1;
          p <= !is_div   ? {suma, p[ANCHO-1:1]} :
               !dif[ANCHO] ? {dif[ANCHO-1:0], p[ANCHO-2:0], 1'b1} : {p[2*ANCHO-2:0], 1'b0};
        end
        AJUSTE:
          if (!dz) begin
            hi <= hi_res;
            lo <= res[ANCHO-1:0];
          end
        default: ;
      endcase
    end
endmodule

// File: tb/tb_unidad_mult_div.sv
// tb_unidad_mult_div: table-driven check of unidad_mult_div plus directed multi-cycle corner cases.
module tb_unidad_mult_div;
  localparam int ANCHO = 32;
  localparam int LAT = ANCHO + 1;
  logic clk = 1'b0, rst_n = 1'b0, inicio = 1'b0, escribe_hi = 1'b0, escribe_lo = 1'b0;
  logic [1:0] operacion = '0;
  logic [ANCHO-1:0] operando_a = '0, operando_b = '0, dato_mt = '0;
  logic ocupado, listo, div_cero;
  logic [ANCHO-1:0] hi, lo;
  int nvec = 0, nerr = 0;

  unidad_mult_div #(.ANCHO(ANCHO)) dut (
    .clk(clk), .rst_n(rst_n), .inicio(inicio), .operacion(operacion),
    .operando_a(operando_a), .operando_b(operando_b), .escribe_hi(escribe_hi),
    .escribe_lo(escribe_lo), .dato_mt(dato_mt), .ocupado(ocupado), .listo(listo),
    .div_cero(div_cero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    string nm;
    logic [1:0] op;
    logic [31:0] a, b, eh, el;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_op(input string nm, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    operacion = op;
    operando_a = a;
    operando_b = b;
    inicio = 1'b1;
    @(posedge clk);
    #1;
    inicio = 1'b0;
    chk({nm, " busy"}, ocupado, 1);
  endtask

  task automatic wait_done(input string nm, input int exp_n, input logic [31:0] eh, input logic [31:0] el, input logic edz);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!listo && n < 200);
    chk({nm, " latency"}, n, exp_n);
    chk({nm, " hi"}, hi, eh);
    chk({nm, " lo"}, lo, el);
    chk({nm, " div_cero"}, div_cero, edz);
    chk({nm, " ocupado in FIN"}, ocupado, 0);
    @(posedge clk);
    #1;
    chk({nm, " pulse ends"}, {listo, div_cero, ocupado}, 0);
  endtask

  task automatic no_listo(input string nm);
    logic seen = 1'b0;
    repeat (ANCHO + 4) begin
      @(posedge clk);
      #1;
      seen |= listo;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    vec_t v[$];
    v.push_back('{"multu max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001});
    v.push_back('{"multu 3x4", 2'b01, 32'd3, 32'd4, 32'd0, 32'd12});
    v.push_back('{"multu 2^16 sq", 2'b01, 32'h00010000, 32'h00010000, 32'd1, 32'd0});
    v.push_back('{"divu 100/7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14});
    v.push_back('{"divu max/1", 2'b11, 32'hFFFFFFFF, 32'd1, 32'd0, 32'hFFFFFFFF});
    v.push_back('{"divu 5/10", 2'b11, 32'd5, 32'd10, 32'd5, 32'd0});
`ifdef MULT_DIV_SIGNED_EN
    v.push_back('{"mult -3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB});
    v.push_back('{"mult 7x-3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB});
    v.push_back('{"div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD});
    v.push_back('{"div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD});
    v.push_back('{"div overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000});
`else
    v.push_back('{"mult -3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'd6, 32'hFFFFFFEB});
    v.push_back('{"mult 7x-3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'd6, 32'hFFFFFFEB});
    v.push_back('{"div -7/2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'd1, 32'h7FFFFFFC});
    v.push_back('{"div 7/-2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd7, 32'd0});
    v.push_back('{"div overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0});
`endif
    #1;
    chk("reset outputs", {ocupado, listo, div_cero, hi, lo}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (v[i]) begin
      start_op(v[i].nm, v[i].op, v[i].a, v[i].b);
      wait_done(v[i].nm, LAT, v[i].eh, v[i].el, 1'b0);
    end

    // MTHI, then simultaneous MTHI+MTLO
    @(negedge clk);
    escribe_hi = 1'b1;
    dato_mt = 32'h1234;
    @(posedge clk);
    #1;
    escribe_hi = 1'b0;
    chk("mthi hi", hi, 32'h1234);
    @(negedge clk);
    escribe_hi = 1'b1;
    escribe_lo = 1'b1;
    dato_mt = 32'hABCD;
    @(posedge clk);
    #1;
    {escribe_hi, escribe_lo} = 2'b00;
    chk("mt both", {hi, lo}, {32'hABCD, 32'hABCD});
    @(negedge clk);
    escribe_hi = 1'b1;
    dato_mt = 32'd5;
    @(negedge clk);
    escribe_hi = 1'b0;
    escribe_lo = 1'b1;
    dato_mt = 32'd9;
    @(negedge clk);
    escribe_lo = 1'b0;
    chk("mt 5/9", {hi, lo}, {32'd5, 32'd9});

    start_op("divu by zero", 2'b11, 32'd100, 32'd0);
    wait_done("divu by zero", 1, 32'd5, 32'd9, 1'b1);

    // second start and MTLO while busy, operands changed mid-CALC
    start_op("busy divu", 2'b11, 32'd100, 32'd7);
    repeat (8) @(posedge clk);
    @(negedge clk);
    operacion = 2'b01;
    operando_a = 32'd2;
    operando_b = 32'd2;
    inicio = 1'b1;
    escribe_lo = 1'b1;
    dato_mt = 32'hDEAD;
    @(posedge clk);
    #1;
    {inicio, escribe_lo} = 2'b00;
    chk("mtlo while busy", lo, 32'd9);
    wait_done("busy divu", LAT - 9, 32'd2, 32'd14, 1'b0);
    no_listo("ignored start not queued");

    // inicio together with MTLO in IDLE: only the op runs
    @(negedge clk);
    operacion = 2'b01;
    operando_a = 32'd3;
    operando_b = 32'd4;
    inicio = 1'b1;
    escribe_lo = 1'b1;
    dato_mt = 32'h5555;
    @(posedge clk);
    #1;
    {inicio, escribe_lo} = 2'b00;
    chk("inicio beats mtlo", lo, 32'd14);
    wait_done("multu with mtlo", LAT, 32'd0, 32'd12, 1'b0);

    // asynchronous reset in the middle of a division
    start_op("div reset", 2'b11, 32'd100, 32'd3);
    repeat (14) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset", {ocupado, listo, hi, lo}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    no_listo("no listo after reset");
    start_op("multu after reset", 2'b01, 32'd3, 32'd4);
    wait_done("multu after reset", LAT, 32'd0, 32'd12, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
